delay_line_capture: RTL and testbench
=====================================

# delay_line_capture

Downstream stage of the enabled shift-register delay line. Watches the delay line's output and its shift enable, discards the unknown or stale words produced while the line fills, and captures each genuinely new output word exactly once into a small FIFO. Words are presented to the next consumer over a valid/ready handshake, so the consumer no longer has to track delay-line fill state or shift timing.

## Interface
Parameters:
- `size`, 10: length of the upstream delay line, in enabled shifts; must match the upstream instance.
- `width`, 8: data word width.
- `depth`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  input  1: clock; all state updates on posedge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `in`  input  width: upstream delay-line output.
- `enable`  input  1: the same enable that drives the upstream delay line.
- `out_data`  output  width: head-of-FIFO word (show-ahead).
- `out_valid`  output  1: FIFO non-empty.
- `out_ready`  input  1: consumer accepts `out_data` this edge.
- `count`  output  $clog2(depth)+1: current FIFO occupancy.
- `overflow`  output  1: sticky flag; a captured word was dropped.

## Operation
- **Fill counter `fill`** (0..size):
  - +1 on each posedge with `enable`=1.
  - Saturates at `size` and never decrements.
  - Upstream output is not meaningful until `size` enabled shifts have occurred.
- **Fresh flag `fresh`** (internal register):
  - At each posedge, `fresh` <= `enable` && (`fill` ≥ size−1), evaluated on the pre-edge `fill`.
  - Meaning: the upstream shift just completed on this edge produced a new valid word.
- **Push:**
  - At a posedge with `fresh`=1, `in` is written to the FIFO tail.
  - A word held by the upstream stage while `enable`=0 is pushed at most once.
- **Pop:** at a posedge with `out_valid`=1 and `out_ready`=1, the head advances.
- **FIFO:**
  - Circular buffer, `depth` entries.
  - Read/write pointers are $clog2(depth) bits and wrap modulo `depth`.
  - `count` is an explicit register.
- **Simultaneous push and pop:**
  - Both take effect and `count` is unchanged.
  - This is legal even when full: the pop frees the slot, so the push succeeds and `overflow` does not set.
- **Push when full without pop:**
  - The word is dropped and the FIFO is unchanged.
  - `overflow` <= 1 and holds until reset.
- **Pop when empty:** no effect; `out_ready` is ignored.
- **`out_data` when empty:** 0 after reset, otherwise the last head word; consumers must qualify it with `out_valid`.
- **Reset** (`reset_n`=0, any time including mid-operation):
  - `fill`, `fresh`, pointers and `count` go to 0.
  - `overflow`=0, `out_valid`=0, `out_data`=0.
  - Stale upstream contents are discarded: `size` new enabled shifts are required before the next capture.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `count`=0, `overflow`=0.
- **Capture latency:**
  - The word shifted into the delay line on enabled edge k (k ≥ 1 after reset) leaves it on enabled edge k+size−1.
  - It is pushed on the following posedge.
  - It is visible on `out_data` with `out_valid`=1 immediately after that push edge, when the FIFO was empty.
- **Back-to-back:** with `enable` held high and `out_ready` held high, throughput is one word per cycle at a constant 1-edge pipeline offset.
- **`enable` dropping:**
  - A low `enable` on edge E clears `fresh` at E.
  - The word present after the last enabled edge is still pushed at E; no further pushes occur until `enable` returns.
- **Outputs:** all outputs are registered or derived from registers only; there is no combinational path from `out_ready` or `in` to any output.

## Test plan
Bench drives a size-10, width-8 upstream delay line plus this block, with `depth`=4.

1. **Startup:** reset, then 20 cycles with `enable`=0 → `out_valid`=0, `count`=0, `out_data`=0 throughout.
2. **First capture:**
   - Stimulus: `enable`=1 with upstream `in` 1,2,3 then 0; `out_ready`=1.
   - No `out_valid` before enabled shift 10.
   - `out_data`=1 is valid one edge after shift 10, followed by 2 and 3 on consecutive cycles.
3. **Enable hold:**
   - Stimulus: after word 1 is captured, `enable`=0 for 20 cycles with `out_ready`=0.
   - `count`=1 and `out_data`=1 throughout; no duplicate push.
   - After re-enable, words 2 and 3 arrive in order.
4. **Overflow:**
   - Stimulus: `out_ready`=0 while 5 words (1..5) are captured.
   - `count`=4 and `overflow`=1 after the 5th push.
   - Popping yields 1,2,3,4; 5 is absent.
5. **Full plus simultaneous:**
   - Stimulus: FIFO full, then a push with `out_ready`=1 on the same edge.
   - `count` stays 4, `overflow` stays 0, and the order of words is preserved.
6. **Reset mid-operation:**
   - Stimulus: pulse `reset_n` low with 2 words stored.
   - All outputs go to their reset values immediately (asynchronously).
   - Next `out_valid` occurs only after 10 new enabled shifts plus 1 edge.

Source files
------------

// File: rtl/delay_line_capture.sv
// Captures each new word leaving an enabled delay line into a show-ahead FIFO; push lands 1 edge after the shift.
// Valid/ready output; a push into a full FIFO with no pop drops the word and sets sticky overflow.
module delay_line_capture #(
  parameter int size  = 10,
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [width-1:0]         in,
  input  logic                     enable,
  output logic [width-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(depth);
  localparam int FW = $clog2(size + 1);
  localparam int CW = AW + 1;

  logic [FW-1:0]    fill_q, fill_d;
  logic             fresh_q, fresh_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] mem_q [depth];

  logic full, pop, push_ok, drop;

  always_comb begin
    fill_d     = fill_q;
    fresh_d    = enable && (fill_q >= FW'(size - 1));
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    head_d     = head_q;

    full    = (count_q == CW'(depth));
    pop     = (count_q != '0) && out_ready;
    push_ok = fresh_q && (!full || pop);
    drop    = fresh_q && full && !pop;

    if (enable && (fill_q != FW'(size))) fill_d = fill_q + FW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
    if (drop) overflow_d = 1'b1;

    // Head is registered; when the new head slot is being written this edge, forward the incoming word.
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = in;
      else                                   head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q     <= '0;
      fresh_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      fill_q     <= fill_d;
      fresh_q    <= fresh_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in;
  end

  assign out_data  = head_q;
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_delay_line_capture.sv
// Directed bench: a size-10 upstream delay line model feeding delay_line_capture (depth 4).
module tb_delay_line_capture;

  localparam int SIZE  = 10;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [2:0]       count;
  logic             overflow;

  logic [SIZE*WIDTH-1:0] dl_q = '0;
  logic [WIDTH-1:0]      dl_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Upstream delay line: not reset, so stale words survive a capture-stage reset.
  always @(posedge clk) begin
    if (enable) dl_q <= {dl_q[(SIZE-1)*WIDTH-1:0], din};
  end
  assign dl_out = dl_q[SIZE*WIDTH-1 -: WIDTH];

  delay_line_capture #(.size(SIZE), .width(WIDTH), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (dl_out),
    .enable    (enable),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
  endtask

  initial begin
    // 1. Startup
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_valid", out_valid, 0);
      check("idle_count", count, 0);
      check("idle_data", out_data, 0);
    end

    // 2. First capture, streaming
    do_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      din = (e <= 3) ? WIDTH'(e) : '0;
      tick();
      check("fill_novalid", out_valid, 0);
    end
    tick();
    check("cap1_valid", out_valid, 1);
    check("cap1_data", out_data, 1);
    tick();
    check("cap2_data", out_data, 2);
    check("cap2_count", count, 1);
    tick();
    check("cap3_data", out_data, 3);
    check("cap3_valid", out_valid, 1);

    // 3. Enable hold: only word 1 captured, then a long stall
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      enable = 1'b1;
      din = (e <= 3) ? WIDTH'(e) : '0;
      tick();
    end
    enable = 1'b0;
    tick();
    check("hold_first_cnt", count, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_count", count, 1);
      check("hold_data", out_data, 1);
    end
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("rearm_count", count, 3);
    check("rearm_head", out_data, 1);
    out_ready = 1'b1;
    tick();
    check("rearm_pop2", out_data, 2);
    tick();
    check("rearm_pop3", out_data, 3);
    tick();
    check("rearm_empty", out_valid, 0);
    check("rearm_lastdata", out_data, 3);

    // 4. Overflow: five captures into four slots
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      din = (e <= 5) ? WIDTH'(e) : '0;
      enable = (e <= 14);
      tick();
      if (e == 14) begin
        check("ovf_full_cnt", count, 4);
        check("ovf_not_yet", overflow, 0);
      end
    end
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", out_data, 1);
    out_ready = 1'b1;
    for (int w = 2; w <= 4; w++) begin
      tick();
      check("ovf_pop", out_data, w);
    end
    tick();
    check("ovf_drained", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // 5. Full plus simultaneous push and pop
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      din = (e <= 5) ? WIDTH'(e) : '0;
      enable = 1'b1;
      tick();
    end
    check("sim_full", count, 4);
    enable = 1'b0;
    out_ready = 1'b1;
    tick();
    check("sim_count", count, 4);
    check("sim_ovf", overflow, 0);
    check("sim_head", out_data, 2);
    for (int w = 3; w <= 5; w++) begin
      tick();
      check("sim_pop", out_data, w);
      check("sim_cnt", count, 6 - w);
    end
    tick();
    check("sim_empty", out_valid, 0);

    // 6. Asynchronous reset mid-operation
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      din = (e <= 2) ? WIDTH'(e) : '0;
      enable = (e <= 11);
      tick();
    end
    check("mid_count", count, 2);
    reset_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", count, 0);
    check("arst_data", out_data, 0);
    check("arst_ovf", overflow, 0);
    #1;
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      enable = 1'b1;
      din = (e == 1) ? 8'd7 : 8'd0;
      tick();
      check("refill_novalid", out_valid, 0);
    end
    tick();
    check("refill_valid", out_valid, 1);
    check("refill_data", out_data, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
